// File: rtl/pbuf2ddr.sv
// ---------------------------------------------------------------------------
// pbuf2ddr
//   Read-back path of the parameter buffers. Drains one PE group (4 units)
//   of pbuf to a DDR write stream: issues ascending pbuf reads, absorbs the
//   fixed pbuf read latency in a credit-guarded FIFO of 4-lane entries, then
//   serialises the masked lanes of each entry into DDR words.
//
//   Optional feature macro: PBUF2DDR_STALL_CNT_EN
//     Adds output stall_cnt[31:0]: cycles with ddr_valid && !ddr_ready since
//     the last start (cleared on start/reset, saturating).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse; latches conf_*, aborts a running job
//   done              high when idle / transfer complete
//   conf_trans_num    last pbuf address (addresses 0..conf_trans_num)
//   conf_grp          PE group to drain
//   conf_unit_mask    units of the group to emit
//   pbuf_rd_addr/en   pbuf read request (only the group's masked enables)
//   pbuf_rd_data      4 lanes, lane j = unit j, valid RD_LAT after rd_en
//   ddr_data/valid    DDR write stream, ddr_ready backpressure
//
// Handshake: a word transfers on ddr_valid && ddr_ready. Once ddr_valid is
// high it stays high with ddr_data stable until the transfer happens; the
// only exception is an abort by start, which drops ddr_valid next cycle.
// ---------------------------------------------------------------------------
module pbuf2ddr #(
    parameter int BUF_DEPTH  = 256,
    parameter int ADDR_W     = $clog2(BUF_DEPTH),
    parameter int PE_NUM     = 32,
    parameter int GRP_W      = $clog2(PE_NUM / 4),
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int BATCH      = 4,
    parameter int DDR_W      = DATA_W * BATCH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      done,
    input  logic [7:0]                conf_trans_num,
    input  logic [GRP_W-1:0]          conf_grp,
    input  logic [3:0]                conf_unit_mask,
    output logic [ADDR_W-1:0]         pbuf_rd_addr,
    output logic [PE_NUM-1:0]         pbuf_rd_en,
    input  logic [3:0][DDR_W-1:0]     pbuf_rd_data,
    output logic [DDR_W-1:0]          ddr_data,
    output logic                      ddr_valid,
`ifdef PBUF2DDR_STALL_CNT_EN
    output logic [31:0]               stall_cnt,
`endif
    input  logic                      ddr_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    done_q;
    logic [7:0]              trans_q;
    logic [GRP_W-1:0]        grp_q;
    logic [3:0]              mask_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [RD_LAT-1:0]       pipe_q;
    logic [3:0][DDR_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              lane_q;

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        occ;
    logic                    issue;
    logic                    push;
    logic                    fire;
    logic                    pop;
    logic [2:0]              lane_d;
    logic [1:0]              first_lane_cur;
    logic [1:0]              first_lane_new;
    logic [3:0][DDR_W-1:0]   head;

    // Lowest masked lane >= from; 3'd4 when there is none.
    function automatic logic [2:0] next_lane(input logic [3:0] m, input logic [2:0] from);
        next_lane = 3'd4;
        for (int j = 3; j >= 0; j--) begin
            if (m[j] && (3'(j) >= from)) next_lane = 3'(j);
        end
    endfunction

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        first_lane = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (m[j]) first_lane = 2'(j);
        end
    endfunction

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        inc_ptr = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i]);
        end
    end

    // Credit check: every issued read already owns a FIFO slot, so returned
    // data can always be written without backpressure toward pbuf.
    assign occ   = cnt_q + inflight;
    assign issue = (state_q == S_READ) && (mask_q != 4'd0) && (occ < CNT_W'(FIFO_DEPTH));
    assign push  = pipe_q[RD_LAT-1];

    assign head           = fifo_q[rd_ptr_q];
    assign lane_d         = next_lane(mask_q, {1'b0, lane_q} + 3'd1);
    assign first_lane_cur = first_lane(mask_q);
    assign first_lane_new = first_lane(conf_unit_mask);

    assign ddr_valid = (cnt_q != '0);
    assign ddr_data  = ddr_valid ? head[lane_q] : '0;
    assign fire      = ddr_valid && ddr_ready;
    // Entry leaves the FIFO when its highest masked lane is accepted.
    assign pop       = fire && lane_d[2];

    assign done         = done_q;
    assign pbuf_rd_addr = addr_q;
    assign pbuf_rd_en   = issue ? (PE_NUM'(mask_q) << {grp_q, 2'b00}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b1;
            trans_q  <= '0;
            grp_q    <= '0;
            mask_q   <= '0;
            addr_q   <= '0;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else if (start) begin
            // Also serves as abort: FIFO and in-flight returns are discarded.
            state_q  <= S_READ;
            done_q   <= 1'b0;
            trans_q  <= conf_trans_num;
            grp_q    <= conf_grp;
            mask_q   <= conf_unit_mask;
            addr_q   <= '0;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            lane_q   <= first_lane_new;
        end else begin
            pipe_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];

            if (push) begin
                fifo_q[wr_ptr_q] <= pbuf_rd_data;
                wr_ptr_q         <= inc_ptr(wr_ptr_q);
            end

            if (pop) begin
                rd_ptr_q <= inc_ptr(rd_ptr_q);
                lane_q   <= first_lane_cur;
            end else if (fire) begin
                lane_q   <= lane_d[1:0];
            end

            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                S_READ: begin
                    if (mask_q == 4'd0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else if (issue) begin
                        if (addr_q == ADDR_W'(trans_q)) state_q <= S_DRAIN;
                        else                             addr_q  <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pop && (cnt_q == CNT_W'(1)) && (inflight == '0)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PBUF2DDR_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start) begin
            stall_q <= '0;
        end else if (ddr_valid && !ddr_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
